// File: rtl/lsu_mem_stage.sv
// RV32I load/store memory stage: handshaked data-memory access with byte-lane masks and load extension.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into a trap instead of a request.
module lsu_mem_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_trap,
  output logic        o_dmem_req,
  output logic [31:0] o_dmem_addr,
  output logic        o_dmem_wen,
  output logic [3:0]  o_dmem_mask,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ready,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_rvalid
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_misalign;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata_rep;

  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic [3:0]  r_mask;
  logic        r_wen;
  logic [31:0] r_rdata;

  // funct3[1] set means word (covers 010, 011, 11x); otherwise funct3[0] picks half vs byte.
  function automatic logic [3:0] f_mask(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] m;
    if (sz[1])      m = 4'b1111;
    else if (sz[0]) m = 4'b0011 << {a[1], 1'b0};
    else            m = 4'b0001 << a;
    return m;
  endfunction

  function automatic logic [31:0] f_wrep(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    if (sz[1])      r = d;
    else if (sz[0]) r = {2{d[15:0]}};
    else            r = {4{d[7:0]}};
    return r;
  endfunction

  function automatic logic [31:0] f_extract(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] r;
    if (f3[1]) begin
      r = word;
    end else if (f3[0]) begin
      sh = word >> {a[1], 4'b0000};
      r  = f3[2] ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    end else begin
      sh = word >> {a, 3'b000};
      r  = f3[2] ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
    end
    return r;
  endfunction

  assign w_accept    = i_valid & (i_mem_read | i_mem_write);
  assign w_mask      = f_mask(i_funct3[1:0], i_addr[1:0]);
  assign w_wdata_rep = f_wrep(i_funct3[1:0], i_wdata);

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_trap;

  assign w_misalign = (i_funct3[1] & (i_addr[1:0] != 2'b00)) |
                      (~i_funct3[1] & i_funct3[0] & i_addr[0]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_trap <= 1'b0;
    else if (r_state == S_IDLE && w_accept)
      r_trap <= w_misalign;
  end

  assign o_trap = (r_state == S_DONE) & r_trap;
`else
  assign w_misalign = 1'b0;
  assign o_trap     = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept)      w_next = w_misalign ? S_DONE : S_REQ;
      S_REQ:  if (i_dmem_ready)  w_next = r_wen ? S_DONE : S_WAIT;
      S_WAIT: if (i_dmem_rvalid) w_next = S_DONE;
      S_DONE:                    w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Request fields are frozen at accept so they stay stable while memory stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr   <= 32'h0;
      r_funct3 <= 3'b000;
      r_wdata  <= 32'h0;
      r_mask   <= 4'b0000;
      r_wen    <= 1'b0;
    end else if (r_state == S_IDLE && w_accept) begin
      r_addr   <= i_addr;
      r_funct3 <= i_funct3;
      r_wdata  <= w_wdata_rep;
      r_mask   <= w_mask;
      r_wen    <= i_mem_write & ~i_mem_read;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_rdata <= 32'h0;
    else if (r_state == S_WAIT && i_dmem_rvalid)
      r_rdata <= f_extract(r_funct3, r_addr[1:0], i_dmem_rdata);
  end

  assign o_stall      = (r_state == S_REQ) | (r_state == S_WAIT) |
                        ((r_state == S_IDLE) & w_accept);
  assign o_done       = (r_state == S_DONE);
  assign o_rdata      = r_rdata;
  assign o_dmem_req   = (r_state == S_REQ);
  assign o_dmem_addr  = {r_addr[31:2], 2'b00};
  assign o_dmem_wen   = r_wen;
  assign o_dmem_mask  = r_mask;
  assign o_dmem_wdata = r_wdata;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: stores, signed/unsigned loads, memory stalls, reset mid-access, misalignment.
module tb_lsu_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_mem_read = 1'b0;
  logic        i_mem_write = 1'b0;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_wdata = 32'h0;
  logic        o_stall;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_trap;
  logic        o_dmem_req;
  logic [31:0] o_dmem_addr;
  logic        o_dmem_wen;
  logic [3:0]  o_dmem_mask;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_ready = 1'b0;
  logic [31:0] i_dmem_rdata = 32'h0;
  logic        i_dmem_rvalid = 1'b0;

  int total = 0;
  int bad = 0;

  lsu_mem_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_done(o_done), .o_rdata(o_rdata), .o_trap(o_trap),
    .o_dmem_req(o_dmem_req), .o_dmem_addr(o_dmem_addr), .o_dmem_wen(o_dmem_wen),
    .o_dmem_mask(o_dmem_mask), .o_dmem_wdata(o_dmem_wdata), .i_dmem_ready(i_dmem_ready),
    .i_dmem_rdata(i_dmem_rdata), .i_dmem_rvalid(i_dmem_rvalid)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge i_clk);
  endtask

  task automatic to_pos();
    @(posedge i_clk);
    #1;
  endtask

  task automatic present(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
    i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr;
    i_funct3 = f3; i_addr = a; i_wdata = d;
  endtask

  task automatic release_inputs();
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
  endtask

  // Load with immediate ready and rvalid one cycle later; returns at the DONE-cycle negedge.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    present(1'b1, 1'b0, f3, a, 32'h0);
    to_pos();
    release_inputs();
    i_dmem_ready = 1'b1;
    to_pos();
    i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = word;
    to_pos();
    i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
    to_neg();
  endtask

  initial begin
    // Reset state
    to_pos(); to_pos();
    to_neg();
    chk1("rst_stall", o_stall, 1'b0);
    chk1("rst_done", o_done, 1'b0);
    chk1("rst_req", o_dmem_req, 1'b0);
    chk32("rst_rdata", o_rdata, 32'h0);
    chk1("rst_trap", o_trap, 1'b0);
    to_pos();
    i_rst = 1'b0;

    // SB to 0x1003, ready in cycle 1
    present(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5);
    to_neg();
    chk1("sb_acc_stall", o_stall, 1'b1);
    chk1("sb_acc_req", o_dmem_req, 1'b0);
    to_pos();
    release_inputs();
    i_dmem_ready = 1'b1;
    to_neg();
    chk1("sb_req", o_dmem_req, 1'b1);
    chk32("sb_addr", o_dmem_addr, 32'h0000_1000);
    chk32("sb_mask", {28'h0, o_dmem_mask}, 32'h8);
    chk32("sb_wdata", o_dmem_wdata, 32'hA5A5_A5A5);
    chk1("sb_wen", o_dmem_wen, 1'b1);
    chk1("sb_req_stall", o_stall, 1'b1);
    to_pos();
    i_dmem_ready = 1'b0;
    to_neg();
    chk1("sb_done", o_done, 1'b1);
    chk1("sb_done_stall", o_stall, 1'b0);
    to_pos();
    to_neg();
    chk1("sb_done_pulse", o_done, 1'b0);
    chk1("sb_idle_req", o_dmem_req, 1'b0);

    // LB 0x2001 with request-side checks
    present(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0);
    to_pos();
    release_inputs();
    i_dmem_ready = 1'b1;
    to_neg();
    chk1("lb_req", o_dmem_req, 1'b1);
    chk1("lb_wen", o_dmem_wen, 1'b0);
    chk32("lb_mask", {28'h0, o_dmem_mask}, 32'h2);
    chk32("lb_addr", o_dmem_addr, 32'h0000_2000);
    to_pos();
    i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h0000_8000;
    to_neg();
    chk1("lb_wait_done", o_done, 1'b0);
    chk1("lb_wait_stall", o_stall, 1'b1);
    chk1("lb_wait_req", o_dmem_req, 1'b0);
    to_pos();
    i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
    to_neg();
    chk1("lb_done", o_done, 1'b1);
    chk32("lb_rdata", o_rdata, 32'hFFFF_FF80);
    chk1("lb_done_stall", o_stall, 1'b0);
    to_pos();
    to_neg();
    chk32("lb_rdata_hold", o_rdata, 32'hFFFF_FF80);
    chk1("lb_done_pulse", o_done, 1'b0);
    to_pos();

    // LBU, same access
    run_load(3'b100, 32'h0000_2001, 32'h0000_8000);
    chk1("lbu_done", o_done, 1'b1);
    chk32("lbu_rdata", o_rdata, 32'h0000_0080);
    to_pos();

    // LH upper half
    run_load(3'b001, 32'h0000_2002, 32'h8001_0000);
    chk32("lh_rdata", o_rdata, 32'hFFFF_8001);
    to_pos();

    // LHU lower half
    run_load(3'b101, 32'h0000_2000, 32'h0000_F00D);
    chk32("lhu_rdata", o_rdata, 32'h0000_F00D);
    to_pos();

    // LW with both strobes (load wins), ready low 3 cycles, stray rvalid during REQ
    present(1'b1, 1'b1, 3'b010, 32'h0000_3004, 32'h5555_5555);
    to_pos();
    release_inputs();
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk1("lw_hold_req", o_dmem_req, 1'b1);
      chk32("lw_hold_addr", o_dmem_addr, 32'h0000_3004);
      chk32("lw_hold_mask", {28'h0, o_dmem_mask}, 32'hF);
      chk1("lw_hold_wen", o_dmem_wen, 1'b0);
      chk1("lw_hold_stall", o_stall, 1'b1);
      to_pos();
    end
    i_dmem_rvalid = 1'b0;
    i_dmem_ready = 1'b1;
    to_neg();
    chk1("lw_req_ready", o_dmem_req, 1'b1);
    to_pos();
    i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h1234_5678;
    to_neg();
    chk1("lw_wait_done", o_done, 1'b0);
    to_pos();
    i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
    to_neg();
    chk1("lw_done", o_done, 1'b1);
    chk32("lw_rdata", o_rdata, 32'h1234_5678);
    to_pos();

    // SH to 0x12: upper lanes, halfword replicated
    present(1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h1234_BEEF);
    to_pos();
    release_inputs();
    i_dmem_ready = 1'b1;
    to_neg();
    chk32("sh_addr", o_dmem_addr, 32'h0000_0010);
    chk32("sh_mask", {28'h0, o_dmem_mask}, 32'hC);
    chk32("sh_wdata", o_dmem_wdata, 32'hBEEF_BEEF);
    to_pos();
    i_dmem_ready = 1'b0;
    to_neg();
    chk1("sh_done", o_done, 1'b1);
    chk32("sh_rdata_kept", o_rdata, 32'h1234_5678);
    to_pos();

    // Reset asserted while waiting for read data
    present(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
    to_pos();
    release_inputs();
    i_dmem_ready = 1'b1;
    to_pos();
    i_dmem_ready = 1'b0;
    i_rst = 1'b1;
    to_neg();
    chk1("rstw_stall", o_stall, 1'b0);
    chk1("rstw_req", o_dmem_req, 1'b0);
    chk32("rstw_addr", o_dmem_addr, 32'h0);
    chk32("rstw_mask", {28'h0, o_dmem_mask}, 32'h0);
    chk1("rstw_wen", o_dmem_wen, 1'b0);
    chk32("rstw_rdata", o_rdata, 32'h0);
    to_pos();
    i_rst = 1'b0;
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hFFFF_FFFF;
    to_neg();
    chk1("rstw_late_done", o_done, 1'b0);
    chk1("rstw_late_stall", o_stall, 1'b0);
    to_pos();
    i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
    to_neg();
    chk1("rstw_after_done", o_done, 1'b0);
    chk32("rstw_after_rdata", o_rdata, 32'h0);
    to_pos();

    // Misaligned LW to 0x3002
    present(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0);
    to_neg();
    chk1("mis_acc_stall", o_stall, 1'b1);
    to_pos();
    release_inputs();
`ifdef LSU_MISALIGN_TRAP_EN
    to_neg();
    chk1("mis_trap", o_trap, 1'b1);
    chk1("mis_done", o_done, 1'b1);
    chk1("mis_req", o_dmem_req, 1'b0);
    chk1("mis_stall", o_stall, 1'b0);
    chk32("mis_rdata", o_rdata, 32'h0);
    to_pos();
    to_neg();
    chk1("mis_trap_pulse", o_trap, 1'b0);
    chk1("mis_done_pulse", o_done, 1'b0);
    chk1("mis_req_after", o_dmem_req, 1'b0);
`else
    i_dmem_ready = 1'b1;
    to_neg();
    chk1("mis_req", o_dmem_req, 1'b1);
    chk32("mis_addr", o_dmem_addr, 32'h0000_3000);
    chk32("mis_mask", {28'h0, o_dmem_mask}, 32'hF);
    chk1("mis_trap", o_trap, 1'b0);
    to_pos();
    i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hCAFE_F00D;
    to_pos();
    i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
    to_neg();
    chk1("mis_done", o_done, 1'b1);
    chk32("mis_rdata", o_rdata, 32'hCAFE_F00D);
    chk1("mis_trap_done", o_trap, 1'b0);
`endif
    to_pos();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit for the RV32I memory stage. It sits directly downstream of the control decoder and the ALU. It consumes the decoded `mem_read`/`mem_write` strobes, `funct3`, the ALU-computed effective address and the rs2 store data. It runs a handshaked request to the data memory, builds byte lanes and write masks, extracts and sign/zero-extends load data, and stalls the pipeline until the access completes.

## Interface
Parameters:
- none (XLEN fixed at 32)

Ports:
- `i_clk` input 1: clock. Everything updates on the rising edge.
- `i_rst` input 1: reset. Asynchronous, active-high.
- `i_valid` input 1: the memory stage holds an instruction.
- `i_mem_read` input 1: load strobe from control.
- `i_mem_write` input 1: store strobe from control.
- `i_funct3` input 3: access size and signedness.
  - `000` LB/SB, `001` LH/SH, `010` LW/SW
  - `100` LBU, `101` LHU
  - `011`/`11x` are treated as word
- `i_addr` input 32: effective byte address (ALU result).
- `i_wdata` input 32: store data (rs2).
- `o_stall` output 1: freezes upstream stages.
- `o_done` output 1: one-cycle pulse when the access completes.
- `o_rdata` output 32: extended load result. Valid while `o_done` is high and held until the next accept.
- `o_trap` output 1: misaligned-access pulse. Only driven when the macro is enabled; otherwise tied 0.
- `o_dmem_req` output 1: memory request valid.
- `o_dmem_addr` output 32: word-aligned address, `{addr[31:2],2'b00}`.
- `o_dmem_wen` output 1: 1 = store, 0 = load.
- `o_dmem_mask` output 4: byte-lane enables.
- `o_dmem_wdata` output 32: lane-replicated store data.
- `i_dmem_ready` input 1: memory accepts the request this cycle.
- `i_dmem_rdata` input 32: read word.
- `i_dmem_rvalid` input 1: read word valid.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - Accept when `i_valid & (i_mem_read | i_mem_write)`.
  - On accept, register addr, funct3, wdata, mask and op, then go to REQ.
  - If both strobes are high, the access is a load.
- **REQ**
  - `o_dmem_req=1`. All request outputs are held stable from registers until `i_dmem_ready`.
  - On ready: a store goes to DONE; a load goes to WAIT.
- **WAIT**
  - On `i_dmem_rvalid`, capture the extracted and extended data into the `o_rdata` register, then go to DONE.
- **DONE**
  - `o_done=1` for one cycle, then go to IDLE.
  - A new access can be accepted in the cycle after DONE.
- **Mask**
  - Byte: `4'b0001 << addr[1:0]`
  - Half: `4'b0011 << {addr[1],1'b0}`
  - Word: `4'b1111`
- **Store data**
  - Byte: `{4{wdata[7:0]}}`
  - Half: `{2{wdata[15:0]}}`
  - Word: `wdata`
- **Load extract**
  - Byte: lane `addr[1:0]`. Half: lane `addr[1]`.
  - Sign-extended when `funct3[2]=0`, zero-extended when `funct3[2]=1`.
- `o_stall = (state != IDLE && state != DONE) | (state == IDLE & accept)`.
- `o_stall` is low in DONE, so the pipeline advances with `o_rdata`.
- **Reset**, including mid-access:
  - State returns to IDLE.
  - All outputs are 0, and `o_rdata` is 0.
  - The outstanding request is abandoned. A late `i_dmem_rvalid` after reset is ignored in IDLE.

## Timing
- Accept at cycle 0. `o_dmem_req` rises at cycle 1.
- Store with immediate ready: ready in cycle 1, `o_done` in cycle 2.
- Load: `i_dmem_rvalid` arrives at cycle ≥2, and `o_done` follows one cycle after rvalid. The minimum load is 3 cycles accept-to-done.
- `i_dmem_rvalid` in REQ is ignored.
- Ready/rvalid arriving in the same cycle is not supported, because memory returns data at least one cycle after acceptance.
- `o_done` and `o_trap` are single-cycle pulses.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A halfword with `addr[0]=1`, or a word with `addr[1:0]!=0`, goes IDLE→DONE with no memory request.
  - In DONE, `o_trap=1` and `o_done=1`; `o_rdata` is unchanged.
  - `o_stall` is high for the accept cycle only.
- Undefined:
  - No check. Low address bits beyond the access size are ignored: a halfword uses `addr[1]`, a word uses none.
  - `o_trap` is constant 0.

## Test plan
- SB, `addr=0x1003`, `wdata=0xA5`, ready in cycle 1 → `o_dmem_addr=0x1000`, `mask=4'b1000`, `wdata=0xA5A5A5A5`, `wen=1`, `o_done` in cycle 2.
- LB, `addr=0x2001`, rdata `0x0000_8000` at cycle 2 → `o_rdata=0xFFFF_FF80` at cycle 3. The same access as LBU → `0x0000_0080`.
- LH, `addr=0x2002`, rdata `0x8001_0000` → `0xFFFF_8001`. LW with ready held low 3 cycles → request outputs stable, `o_stall=1` throughout, done 1 cycle after rvalid.
- Reset asserted in WAIT, then rvalid pulsed → state IDLE, all outputs 0, no `o_done`.
- LW `addr=0x3002` with `LSU_MISALIGN_TRAP_EN`:
  - `o_dmem_req` never asserted; `o_trap=o_done=1` at cycle 1.
  - Without the macro: request to `0x3000` with `mask=4'b1111`.
